// File: rtl/fetch_seq.sv
// IF-stage fetch sequencer: owns the PC, fetches words from imem over req/ack, honours stall and EX redirects.
// Optional perf counters (fetch_cnt, stall_cnt, redir_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_seq #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
    parameter int                         CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic [1:0]               pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    output logic                     flush_d,
    output logic [1:0]               fsm_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     fetch_cnt,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     redir_cnt
`endif
);

    // imem handshake: a request is presented while imem_req=1 and completes in the
    // cycle imem_ack=1; imem_addr stays constant from the first req cycle until ack.
    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_OUT} state_t;

    state_t                     state, state_n;
    logic [ADDRESS_WIDTH-1:0]   pc_n;
    logic [ADDRESS_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]      instr_n;
    logic                       drop, drop_n;
    logic                       redirect;
    logic [ADDRESS_WIDTH-1:0]   redirect_pc;

    assign redirect    = (pc_src_e == 2'b01 || pc_src_e == 2'b10) && (state != S_BOOT);
    assign redirect_pc = (pc_src_e == 2'b01) ? (pc_target_e & ~ADDRESS_WIDTH'(3)) : RESET_VECTOR;

    assign pc_plus4    = pc + ADDRESS_WIDTH'(4);
    assign imem_req    = (state == S_REQ) || (state == S_WAIT);
    assign imem_addr   = (state == S_WAIT) ? req_addr : pc;
    assign instr_valid = (state == S_OUT);
    assign fsm_state   = state;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        drop_n  = drop;
        case (state)
            S_BOOT: state_n = S_REQ;
            S_REQ, S_WAIT: begin
                if (imem_ack) begin
                    // A response owed to an abandoned PC is thrown away.
                    if (redirect || drop) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        instr_n = imem_rdata;
                        state_n = S_OUT;
                    end
                end else begin
                    state_n = S_WAIT;
                    if (redirect) drop_n = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    state_n = S_REQ;
                end else if (!stall_f) begin
                    pc_n    = pc_plus4;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_BOOT;
        endcase
        if (redirect) pc_n = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_BOOT;
            pc       <= RESET_VECTOR;
            req_addr <= RESET_VECTOR;
            instr    <= '0;
            drop     <= 1'b0;
            flush_d  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr    <= instr_n;
            drop     <= drop_n;
            flush_d  <= redirect;
            if (state == S_REQ) req_addr <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (instr_valid && !stall_f) fetch_cnt <= sat_inc(fetch_cnt);
            if ((state == S_WAIT) || (instr_valid && stall_f)) stall_cnt <= sat_inc(stall_cnt);
            if (redirect) redir_cnt <= sat_inc(redir_cnt);
        end
    end
`endif

endmodule
